// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared state encoding and gate sizing helpers for freq_meter
package freq_meter_pkg;

    typedef enum logic [1:0] {
        WARMUP,
        IDLE,
        MEASURE,
        DONE
    } fm_state_t;

    // Cycles spent letting the synchronizer fill before edges are trusted.
    localparam int WARMUP_CYCLES = 3;

    function automatic int gate_cycles(input int clk_hz, input int gate_hz);
        return clk_hz / gate_hz;
    endfunction

    function automatic int gate_width(input int clk_hz, input int gate_hz);
        int cycles;
        cycles = gate_cycles(clk_hz, gate_hz);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - 2-flop synchronizer plus history flop producing a rising-edge pulse
module edge_sync (
    input  logic clock,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clock) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse = s2 & ~s3;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated edge-count frequency meter; FREQ_METER_PERIOD_EN adds last-period capture
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int GATE_HZ    = 10,
    parameter int CNT_W      = 26,
    parameter int CONTINUOUS = 1
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] freq_hz,
    output logic             overflow,
    output logic [CNT_W-1:0] period_cycles
);

    localparam int                GATE_CYCLES = gate_cycles(CLK_HZ, GATE_HZ);
    localparam int                GATE_W      = gate_width(CLK_HZ, GATE_HZ);
    localparam logic [GATE_W-1:0] GATE_LAST   = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W+7:0]  GATE_MUL    = (CNT_W + 8)'(GATE_HZ);

    fm_state_t         state;
    fm_state_t         state_next;
    logic [1:0]        warm_cnt;
    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic              sat;
    logic              edge_pulse;

    edge_sync u_edge_sync (
        .clock (clock),
        .rst   (rst),
        .din   (sig_in),
        .pulse (edge_pulse)
    );

    always_comb begin
        state_next = state;
        case (state)
            WARMUP: begin
                if (warm_cnt == 2'(WARMUP_CYCLES - 1)) begin
                    state_next = (CONTINUOUS != 0) ? MEASURE : IDLE;
                end
            end
            IDLE: begin
                if (start && (CONTINUOUS == 0)) begin
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (gate_cnt == GATE_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = (CONTINUOUS != 0) ? MEASURE : IDLE;
            end
            default: state_next = WARMUP;
        endcase
    end

    assign busy = (state == MEASURE) || (state == DONE);

    // Counters are cleared in DONE so every MEASURE entry starts from zero.
    always_ff @(posedge clock) begin
        if (rst) begin
            state    <= WARMUP;
            warm_cnt <= 2'd0;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            valid    <= 1'b0;
            freq_hz  <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            valid <= 1'b0;
            case (state)
                WARMUP: warm_cnt <= warm_cnt + 1'b1;
                MEASURE: begin
                    gate_cnt <= gate_cnt + 1'b1;
                    if (edge_pulse) begin
                        if (&edge_cnt) begin
                            sat <= 1'b1;
                        end else begin
                            edge_cnt <= edge_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    freq_hz  <= CNT_W'({8'd0, edge_cnt} * GATE_MUL);
                    overflow <= sat;
                    valid    <= 1'b1;
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    sat      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef FREQ_METER_PERIOD_EN
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] per_shadow;
    logic             seen;

    // per_cnt restarts at 1 on an edge so the next edge latches the full spacing.
    always_ff @(posedge clock) begin
        if (rst) begin
            per_cnt       <= '0;
            per_shadow    <= '0;
            seen          <= 1'b0;
            period_cycles <= '0;
        end else begin
            case (state)
                MEASURE: begin
                    if (edge_pulse) begin
                        if (seen) begin
                            per_shadow <= per_cnt;
                        end
                        seen    <= 1'b1;
                        per_cnt <= CNT_W'(1);
                    end else if (~&per_cnt) begin
                        per_cnt <= per_cnt + 1'b1;
                    end
                end
                DONE: begin
                    period_cycles <= per_shadow;
                    per_cnt       <= '0;
                    per_shadow    <= '0;
                    seen          <= 1'b0;
                end
                default: ;
            endcase
        end
    end
`else
    assign period_cycles = '0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - directed self-checking bench for freq_meter (gate of 100 cycles)
module tb_freq_meter;

    logic        clock = 1'b0;
    logic        rst   = 1'b1;
    logic        sig_a = 1'b1;
    logic        sig_b = 1'b0;
    logic        sig_c = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        start_c = 1'b0;

    logic        busy_a, valid_a, ovf_a;
    logic [25:0] freq_a, per_a;
    logic        busy_b, valid_b, ovf_b;
    logic [4:0]  freq_b, per_b;
    logic        busy_c, valid_c, ovf_c;
    logic [25:0] freq_c, per_c;

    int cyc    = 0;
    int mode_a = 1;
    int mode_c = 2;
    int errors = 0;
    int checks = 0;
    int n;
    int vcount;
    int vfirst;

    always #5 clock = ~clock;

    freq_meter #(.CLK_HZ(1000), .GATE_HZ(10), .CNT_W(26), .CONTINUOUS(1)) dut_a (
        .clock(clock), .rst(rst), .sig_in(sig_a), .start(start_a),
        .busy(busy_a), .valid(valid_a), .freq_hz(freq_a), .overflow(ovf_a),
        .period_cycles(per_a)
    );

    freq_meter #(.CLK_HZ(1000), .GATE_HZ(10), .CNT_W(5), .CONTINUOUS(1)) dut_b (
        .clock(clock), .rst(rst), .sig_in(sig_b), .start(start_b),
        .busy(busy_b), .valid(valid_b), .freq_hz(freq_b), .overflow(ovf_b),
        .period_cycles(per_b)
    );

    freq_meter #(.CLK_HZ(1000), .GATE_HZ(10), .CNT_W(26), .CONTINUOUS(0)) dut_c (
        .clock(clock), .rst(rst), .sig_in(sig_c), .start(start_c),
        .busy(busy_c), .valid(valid_c), .freq_hz(freq_c), .overflow(ovf_c),
        .period_cycles(per_c)
    );

    // mode 0 = low, 1 = high, 2 = square wave with a 10-cycle period
    task automatic step();
        @(negedge clock);
        cyc = cyc + 1;
        sig_a = (mode_a == 2) ? ((cyc % 10) < 5) : (mode_a == 1);
        sig_c = (mode_c == 2) ? ((cyc % 10) < 5) : (mode_c == 1);
        sig_b = ~sig_b;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int which, input int budget, output int cnt);
        cnt = budget + 1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if ((which == 0 && valid_a) || (which == 2 && valid_c)) begin
                cnt = i;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (4) step();
        check("rst_busy", busy_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_freq", freq_a, 0);
        check("rst_overflow", ovf_a, 0);
        check("rst_period", per_a, 0);

        // sig_a held high from before reset: no spurious edge in the first gate
        rst = 1'b0;
        wait_valid(0, 300, n);
        check("first_latency", n, 104);
        check("stuck_high_freq", freq_a, 0);
        check("stuck_high_ovf", ovf_a, 0);
        check("sat_valid_b", valid_b, 1);
        check("sat_freq_b", freq_b, 22);
        check("sat_ovf_b", ovf_b, 1);

        mode_a = 2;
        step();
        check("valid_one_cycle", valid_a, 0);
        wait_valid(0, 200, n);
        check("interval_1", n, 100);
        wait_valid(0, 200, n);
        check("interval_2", n, 101);
        check("p10_freq", freq_a, 100);
        check("p10_ovf", ovf_a, 0);
        repeat (50) step();
        check("hold_valid", valid_a, 0);
        check("hold_freq", freq_a, 100);
        check("mid_gate_busy", busy_a, 1);

        // reset 50 cycles into a gate
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", busy_a, 0);
        check("abort_valid", valid_a, 0);
        check("abort_freq", freq_a, 0);
        check("abort_ovf", ovf_a, 0);
        wait_valid(0, 300, n);
        check("abort_latency", n, 104);
        check("abort_next_freq", freq_a, 100);
        check("oneshot_idle_busy", busy_c, 0);

        // one-shot: a second start 20 cycles into the gate is ignored
        start_c = 1'b1;
        step();
        start_c = 1'b0;
        vcount = 0;
        vfirst = 0;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (i == 20) check("oneshot_busy", busy_c, 1);
            if (valid_c) begin
                vcount++;
                if (vfirst == 0) vfirst = i;
            end
            start_c = (i == 19);
        end
        check("oneshot_count", vcount, 1);
        check("oneshot_latency", vfirst, 101);
        check("oneshot_after_busy", busy_c, 0);
        check("oneshot_freq", freq_c, 100);
        check("oneshot_ovf", ovf_c, 0);
`ifdef FREQ_METER_PERIOD_EN
        check("period_p10", per_c, 10);
`else
        check("period_tied", per_c, 0);
`endif

        // exactly one rising edge inside the gate
        mode_c = 0;
        repeat (5) step();
        start_c = 1'b1;
        step();
        start_c = 1'b0;
        repeat (30) step();
        mode_c = 1;
        wait_valid(2, 200, n);
        check("single_latency", n, 71);
        check("single_freq", freq_c, 10);
        check("single_ovf", ovf_c, 0);
        check("single_period", per_c, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the frequency of an external square wave, such as a tone from the board's clock dividers or an external oscillator input.
- Counts rising edges of the input over a fixed gate window derived from the system clock, then reports the result in Hz.
- Sits beside the tone generators as a self-check and tuner block. Drives the 7-segment display path and the test harness.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- GATE_HZ, 10, gate windows per second. The gate is GATE_CYCLES = CLK_HZ/GATE_HZ clock cycles.
- CNT_W, 26, width of the edge counter and of freq_hz.
- CONTINUOUS, 1, when 1, a new gate starts automatically after each result. When 0, one gate runs per start pulse.

Ports:
- clock, input, 1, system clock, rising-edge.
- rst, input, 1, synchronous, active-high reset.
- sig_in, input, 1, measured signal. Asynchronous to clock.
- start, input, 1, single-cycle request to begin a gate. Used only when CONTINUOUS=0.
- busy, output, 1, high while a gate is in progress.
- valid, output, 1, one-cycle pulse when freq_hz and overflow update.
- freq_hz, output, CNT_W, last measured frequency: edges in the gate times GATE_HZ, truncated to CNT_W bits.
- overflow, output, 1, last gate saturated the edge counter.
- period_cycles, output, CNT_W, see Optional Feature.

Behaviour:
- Reset values:
  - busy=0, valid=0, freq_hz=0, overflow=0, period_cycles=0.
  - State=WARMUP, and all counters are 0.
- Input path: a 2-flop synchronizer feeds a history flop. edge = s2 & ~s3. All three flops reset to 0.
- WARMUP state:
  - Lasts 3 cycles after reset deassertion, while the synchronizer fills.
  - Edges are ignored during warm-up.
  - Next state is MEASURE if CONTINUOUS=1, otherwise IDLE.
- IDLE state:
  - busy=0.
  - start=1 moves to MEASURE on the next cycle, with gate_cnt=0 and edge_cnt=0.
- MEASURE state:
  - busy=1.
  - gate_cnt increments every cycle, over 0..GATE_CYCLES-1.
  - edge_cnt increments on each edge and saturates at all-ones. If the increment would wrap, the sat flag is set instead.
  - An edge on the final gate cycle (gate_cnt=GATE_CYCLES-1) is counted.
  - After the final gate cycle, go to DONE.
- DONE state, exactly 1 cycle:
  - freq_hz <= edge_cnt*GATE_HZ. The multiply is CNT_W+8 wide internally; the low CNT_W bits are kept.
  - overflow <= sat, and valid=1 in this same cycle.
  - busy stays 1 in DONE.
  - Next state is MEASURE (counters cleared) if CONTINUOUS=1, else IDLE.
  - Edges arriving during the DONE cycle are not counted. This one-cycle dead time per gate is accepted.
- Latency: valid is asserted GATE_CYCLES+1 cycles after the MEASURE entry cycle.
- start rules:
  - start while busy=1, or during WARMUP, is ignored. There is no queuing.
  - start is ignored entirely when CONTINUOUS=1.
- Constant input (stuck high or low): the result is 0 Hz with overflow=0.
- Maximum countable rate is CLK_HZ/2, because an edge requires s2 to toggle.
- rst mid-gate: all state is discarded, outputs return to reset values and WARMUP is re-entered. No valid pulse is produced for the aborted gate.
- freq_hz and overflow hold their values between valid pulses.

Optional Feature:
- Macro: FREQ_METER_PERIOD_EN.
- Defined:
  - A period counter counts clock cycles between consecutive edges during MEASURE.
  - On each edge after the first in a gate, the count is latched into a shadow register and the counter restarts.
  - In DONE, period_cycles <= shadow, which is the last full period in the gate, or 0 if fewer than 2 edges occurred.
  - The period counter saturates at all-ones.
  - The period counter is cleared at each MEASURE entry.
- Not defined: period_cycles is tied to 0 and no period logic is synthesized.

Decomposition:
- Package freq_meter_pkg holds:
  - the state enum fm_state_t {WARMUP, IDLE, MEASURE, DONE};
  - the localparam function computing GATE_CYCLES and its width, $clog2(GATE_CYCLES).
- Sub-module edge_sync:
  - 2-flop synchronizer plus history flop.
  - Outputs a one-cycle rising-edge pulse.
  - Reused later by other async inputs.

Test Plan:
- CLK_HZ=1000, GATE_HZ=10 (gate = 100 cycles), CONTINUOUS=1, sig period 10 cycles -> valid every 101 cycles, freq_hz=100, overflow=0.
- Same configuration, sig held at 1 from before reset -> no spurious edge, first result freq_hz=0.
- Same configuration, sig toggling every cycle (period 2) -> freq_hz=500. With CNT_W=5, edge_cnt saturates at 31 -> overflow=1, freq_hz=310 truncated to 5 bits = 22.
- CONTINUOUS=0, start pulse, then a second start 20 cycles later -> exactly one valid, 101 cycles after the first start; busy low afterwards.
- rst asserted 50 cycles into a gate -> no valid pulse; outputs return to 0; next result follows 3 warm-up cycles plus a full gate.
- FREQ_METER_PERIOD_EN defined, sig period 10 -> period_cycles=10. With 1 edge per gate -> period_cycles=0.
